bcd_scan_counter: RTL
=====================

BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

Interface
REQ-001 Parameter CNT_DIV, default 4, clk cycles per count step while enabled (>=1).
REQ-002 Parameter SCAN_DIV, default 2, clk cycles each digit stays selected (>=1).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 en  input  1  count enable; gates prescaler and count.
REQ-006 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 clr  input  1  synchronous clear of count to 0000.
REQ-008 load  input  1  synchronous load of load_val.
REQ-009 load_val  input  16  four BCD digits, [3:0] = units digit.
REQ-010 count  output  16  current four-digit BCD value, [3:0] = units.
REQ-011 carry  output  1  one-cycle pulse on wrap 9999->0000 (up) or 0000->9999 (down).
REQ-012 load_err  output  1  one-cycle pulse when a load contained a digit >9.
REQ-013 data  output  4  BCD digit currently scanned; feeds the 7-segment decoder data input.
REQ-014 dig_sel  output  4  one-hot, active-high digit select; bit i selects digit i.

Function
REQ-015 Priority per cycle SHALL be rst > clr > load > count step.
REQ-016 Prescaler SHALL count 0..CNT_DIV-1 only while en=1, hold while en=0, and return to 0 on rst, clr or load.
REQ-017 A count step SHALL occur on the edge where en=1 and prescaler=CNT_DIV-1; count updates at that edge.
REQ-018 Up step: units +1; a digit at 9 SHALL go to 0 and propagate a carry to the next digit in the same cycle.
REQ-019 Down step: units -1; a digit at 0 SHALL go to 9 and propagate a borrow to the next digit in the same cycle.
REQ-020 carry SHALL be 1 in exactly the cycle after a step that wraps all four digits, else 0.
REQ-021 Each count digit SHALL remain in 0..9 at all times.
REQ-022 On load, valid digits (<=9) SHALL load as given; invalid digits SHALL load as 0 and load_err SHALL pulse the next cycle.
REQ-023 A direction change on up SHALL take effect at the next step, with no extra or lost step.
REQ-024 Scan index SHALL advance 0->1->2->3->0 every SCAN_DIV cycles, independent of en, clr and load.
REQ-025 data SHALL equal count digit[scan index] and dig_sel SHALL equal 1<<scan index, both registered and consistent in the same cycle.
REQ-026 Latency from a count update to its appearance on data SHALL be at most 1 cycle after that digit is selected.

Reset
REQ-027 On rst: count=0000, prescaler=0, scan index=0, carry=0, load_err=0, data=0000, dig_sel=0001.
REQ-028 rst asserted mid-step or mid-load SHALL discard that step or load; clr or load asserted with rst SHALL be ignored.

Structure
REQ-029 Package bcd_pkg SHALL hold NUM_DIGITS=4, BCD_MAX=4'd9 and the BCD digit typedef.
REQ-030 One sub-module bcd_digit (single digit, step/up inputs, carry-or-borrow in and out, load, clear) SHALL be instantiated NUM_DIGITS times.
REQ-031 The scan multiplexer and prescaler SHALL live in bcd_scan_counter.

Verification
REQ-032 rst, then en=1 up=1 for 10 steps (CNT_DIV=4: 40 cycles) -> count=0010, carry never 1.
REQ-033 load 16'h9998, up=1, 2 steps -> 9999 then 0000; carry=1 for exactly one cycle after the wrap.
REQ-034 load 16'h0001, up=0, 2 steps -> 0000 then 9999; carry pulses once.
REQ-035 load 16'h12F4 -> count=1204, load_err pulses one cycle; clr and load in the same cycle -> count=0000.
REQ-036 count=4321, observe 8 scan slots -> data 1,2,3,4,1,2,3,4 with dig_sel 0001,0010,0100,1000 repeating, SCAN_DIV cycles each.
REQ-037 en toggled low for 3 cycles mid-prescale -> step delayed by exactly 3 cycles; rst mid-run -> all outputs match REQ-027 next cycle.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD types and constants for the four-digit scanned counter.
package bcd_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 4;

  typedef logic [DIGIT_W-1:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  function automatic logic is_bcd(input bcd_t d);
    return d <= BCD_MAX;
  endfunction

  // Out-of-range digits collapse to zero so the count never leaves 0..9.
  function automatic bcd_t sanitize(input bcd_t d);
    return is_bcd(d) ? d : '0;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the BCD counter: up/down step with ripple carry/borrow, load and clear.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                load,
  input  logic [DIGIT_W-1:0]  load_val,
  input  logic                step,
  input  logic                up,
  input  logic                cin,
  output logic                cout_c,
  output logic [DIGIT_W-1:0]  digit
);

  bcd_t nxt_c;

  // Neighbouring value in the current direction, wrapping at the decade edge.
  always_comb begin
    nxt_c = digit;
    if (up) nxt_c = (digit >= BCD_MAX) ? '0 : digit + 4'd1;
    else    nxt_c = (digit == '0) ? BCD_MAX : digit - 4'd1;
  end

  assign cout_c = cin & (up ? (digit >= BCD_MAX) : (digit == '0));

  always_ff @(posedge clk) begin
    if (rst)                digit <= '0;
    else if (clr)           digit <= '0;
    else if (load)          digit <= sanitize(load_val);
    else if (step && cin)   digit <= nxt_c;
  end

endmodule

// File: rtl/bcd_scan_counter.sv
// Four-digit BCD up/down counter with prescaled stepping and a multiplexed digit scan.
module bcd_scan_counter
  import bcd_pkg::*;
#(
  parameter int unsigned CNT_DIV  = 4,
  parameter int unsigned SCAN_DIV = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          up,
  input  logic                          clr,
  input  logic                          load,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] load_val,
  output logic [NUM_DIGITS*DIGIT_W-1:0] count,
  output logic                          carry,
  output logic                          load_err,
  output logic [DIGIT_W-1:0]            data,
  output logic [NUM_DIGITS-1:0]         dig_sel
);

  localparam int unsigned PW = (CNT_DIV  > 1) ? $clog2(CNT_DIV)  : 1;
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = $clog2(NUM_DIGITS);

  logic [PW-1:0]       presc;
  logic                presc_wrap_c;
  logic                step_c;
  logic                bad_c;
  logic [NUM_DIGITS:0] chain;
  bcd_t                digits [NUM_DIGITS];

  logic [SW-1:0]       scan_cnt;
  logic                scan_wrap_c;
  logic [IW-1:0]       scan_idx;
  logic [IW-1:0]       idx_nxt_c;

  assign presc_wrap_c = (presc == PW'(CNT_DIV - 1));
  assign step_c       = en & presc_wrap_c & ~clr & ~load;

  // Prescaler only advances while enabled; any clear or load restarts the step interval.
  always_ff @(posedge clk) begin
    if (rst || clr || load) presc <= '0;
    else if (en)            presc <= presc_wrap_c ? '0 : presc + PW'(1);
  end

  assign chain[0] = 1'b1;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .load     (load),
      .load_val (load_val[DIGIT_W*i +: DIGIT_W]),
      .step     (step_c),
      .up       (up),
      .cin      (chain[i]),
      .cout_c   (chain[i+1]),
      .digit    (digits[i])
    );
    assign count[DIGIT_W*i +: DIGIT_W] = digits[i];
  end

  always_comb begin
    bad_c = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (!is_bcd(load_val[DIGIT_W*i +: DIGIT_W])) bad_c = 1'b1;
    end
  end

  // A carry out of the top digit means every digit wrapped on this step.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry    <= 1'b0;
      load_err <= 1'b0;
    end else begin
      carry    <= step_c & chain[NUM_DIGITS];
      load_err <= load & ~clr & bad_c;
    end
  end

  assign scan_wrap_c = (scan_cnt == SW'(SCAN_DIV - 1));

  always_comb begin
    idx_nxt_c = scan_idx;
    if (scan_wrap_c) idx_nxt_c = scan_idx + IW'(1);
  end

  // data and dig_sel are both taken from the next index so they always agree.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      data     <= '0;
      dig_sel  <= NUM_DIGITS'(1);
    end else begin
      scan_cnt <= scan_wrap_c ? '0 : scan_cnt + SW'(1);
      scan_idx <= idx_nxt_c;
      data     <= digits[idx_nxt_c];
      dig_sel  <= NUM_DIGITS'(1) << idx_nxt_c;
    end
  end

endmodule
